// File: rtl/ppu_vram_port_if.sv
// Bus bundle between the CPU/render/memory side and the PPUADDR/PPUDATA access engine.
// The engine connects through the slave modport; the surrounding system uses master.
interface ppu_vram_port_if #(
  parameter int unsigned ADDR_W = 14
);
  // CPU register access
  logic              cpu_sel;
  logic [2:0]        cpu_reg;
  logic              cpu_rw;
  logic [7:0]        cpu_data_i;
  logic [7:0]        cpu_data_o;
  logic              inc32;
  // Render fetch
  logic              rend_req;
  logic [ADDR_W-1:0] rend_addr;
  logic              rend_valid;
  // Memory map port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rw;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_data_i;
  // Palette RAM side port
  logic              pal_we;
  logic [4:0]        pal_addr;
  logic [7:0]        pal_wdata;
  logic [7:0]        pal_rdata;
  // Status
  logic              busy;
  logic              drop;

  modport slave (
    input  cpu_sel, cpu_reg, cpu_rw, cpu_data_i, inc32,
    input  rend_req, rend_addr,
    input  mem_data_i, pal_rdata,
    output cpu_data_o, rend_valid,
    output mem_addr, mem_rw, mem_wdata,
    output pal_we, pal_addr, pal_wdata,
    output busy, drop
  );

  modport master (
    output cpu_sel, cpu_reg, cpu_rw, cpu_data_i, inc32,
    output rend_req, rend_addr,
    output mem_data_i, pal_rdata,
    input  cpu_data_o, rend_valid,
    input  mem_addr, mem_rw, mem_wdata,
    input  pal_we, pal_addr, pal_wdata,
    input  busy, drop
  );
endinterface

// File: rtl/ppu_vram_port.sv
// PPUADDR/PPUDATA access engine: VRAM address/toggle registers, read buffer,
// single-slot CPU access queue arbitrated behind render fetches, and palette side port.
module ppu_vram_port #(
  parameter int unsigned ADDR_W   = 14,
  parameter logic [5:0]  PAL_PAGE = 6'h3F
) (
  input logic            clk,
  input logic            rst,
  ppu_vram_port_if.slave bus
);

  localparam int unsigned HiW = ADDR_W - 8;

  logic [ADDR_W-1:0] v_q, v_d;
  logic [ADDR_W-1:0] t_q, t_d;
  logic              w_q, w_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_rw_q, pend_rw_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic [7:0]        rd_buf_q, rd_buf_d;
  logic [7:0]        cpu_data_q, cpu_data_d;
  logic              rd_ret_q, rd_ret_d;
  logic              rend_valid_q;

  logic              acc2_rd;
  logic              acc6_wr;
  logic              acc7;
  logic              acc7_ok;
  logic              is_pal;
  logic              issue_cpu;
  logic [ADDR_W-1:0] v_inc;
  logic [ADDR_W-1:0] nt_addr;

  // Access decode
  assign acc2_rd   = bus.cpu_sel && (bus.cpu_reg == 3'd2) && bus.cpu_rw;
  assign acc6_wr   = bus.cpu_sel && (bus.cpu_reg == 3'd6) && !bus.cpu_rw;
  assign acc7      = bus.cpu_sel && (bus.cpu_reg == 3'd7);
  assign acc7_ok   = acc7 && !pend_q;
  assign is_pal    = (v_q[ADDR_W-1:ADDR_W-6] == PAL_PAGE);
  assign issue_cpu = pend_q && !bus.rend_req;
  assign v_inc     = v_q + (bus.inc32 ? ADDR_W'(32) : ADDR_W'(1));
  // Palette reads refill the buffer from the nametable mirror underneath.
  assign nt_addr   = {2'b10, v_q[ADDR_W-3:0]};

  always_comb begin
    v_d         = v_q;
    t_d         = t_q;
    w_d         = w_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_rw_d   = pend_rw_q;
    pend_data_d = pend_data_q;
    rd_buf_d    = rd_buf_q;
    cpu_data_d  = cpu_data_q;
    rd_ret_d    = issue_cpu && pend_rw_q;

    if (rd_ret_q) begin
      rd_buf_d = bus.mem_data_i;
    end
    if (issue_cpu) begin
      pend_d = 1'b0;
    end

    if (acc2_rd) begin
      w_d = 1'b0;
    end

    if (acc6_wr) begin
      if (!w_q) begin
        t_d[ADDR_W-1:8] = bus.cpu_data_i[HiW-1:0];
        w_d             = 1'b1;
      end else begin
        t_d[7:0] = bus.cpu_data_i;
        v_d      = {t_q[ADDR_W-1:8], bus.cpu_data_i};
        w_d      = 1'b0;
      end
    end

    // Accepted only with an empty slot, so it never collides with issue_cpu.
    if (acc7_ok) begin
      v_d = v_inc;
      if (!bus.cpu_rw) begin
        if (!is_pal) begin
          pend_d      = 1'b1;
          pend_addr_d = v_q;
          pend_rw_d   = 1'b0;
          pend_data_d = bus.cpu_data_i;
        end
      end else begin
        pend_d    = 1'b1;
        pend_rw_d = 1'b1;
        if (is_pal) begin
          cpu_data_d  = bus.pal_rdata;
          pend_addr_d = nt_addr;
        end else begin
          cpu_data_d  = rd_buf_q;
          pend_addr_d = v_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q          <= '0;
      t_q          <= '0;
      w_q          <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_rw_q    <= 1'b0;
      pend_data_q  <= '0;
      rd_buf_q     <= '0;
      cpu_data_q   <= '0;
      rd_ret_q     <= 1'b0;
      rend_valid_q <= 1'b0;
    end else begin
      v_q          <= v_d;
      t_q          <= t_d;
      w_q          <= w_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_rw_q    <= pend_rw_d;
      pend_data_q  <= pend_data_d;
      rd_buf_q     <= rd_buf_d;
      cpu_data_q   <= cpu_data_d;
      rd_ret_q     <= rd_ret_d;
      rend_valid_q <= bus.rend_req;
    end
  end

  // Memory port: render first, then the queued CPU access, else idle read of v.
  always_comb begin
    bus.mem_addr  = v_q;
    bus.mem_rw    = 1'b1;
    bus.mem_wdata = pend_data_q;
    if (bus.rend_req) begin
      bus.mem_addr = bus.rend_addr;
    end else if (pend_q) begin
      bus.mem_addr = pend_addr_q;
      bus.mem_rw   = pend_rw_q;
    end
  end

  assign bus.pal_we     = rst && acc7_ok && !bus.cpu_rw && is_pal;
  assign bus.pal_addr   = v_q[4:0];
  assign bus.pal_wdata  = bus.cpu_data_i;
  assign bus.drop       = rst && acc7 && pend_q;
  assign bus.busy       = pend_q;
  assign bus.cpu_data_o = cpu_data_q;
  assign bus.rend_valid = rend_valid_q;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Directed bench for ppu_vram_port: memory/palette models plus a write scoreboard
// that expects each queued CPU write to appear on the memory port in order.
module tb_ppu_vram_port;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ppu_vram_port_if #(.ADDR_W(14)) bus ();

  ppu_vram_port #(
    .ADDR_W  (14),
    .PAL_PAGE(6'h3F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [7:0]  mem [0:16383];
  logic [7:0]  pal [0:31];
  logic [13:0] rd_addr_n;
  wr_t         wq[$];
  wr_t         exp_w;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        snap_pal_we, snap_drop;
  logic [4:0]  snap_pal_addr;
  logic [7:0]  snap_pal_wdata;

  assign bus.pal_rdata = pal[bus.pal_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory and palette models; every memory write is matched against the scoreboard.
  always @(negedge clk) begin
    rd_addr_n = bus.mem_addr;
    if (bus.pal_we === 1'b1) pal[bus.pal_addr] = bus.pal_wdata;
    if (rst === 1'b1 && bus.mem_rw === 1'b0) begin
      mem[bus.mem_addr] = bus.mem_wdata;
      n_checks++;
      assert (wq.size() != 0) else begin
        n_errors++;
        $error("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
               bus.mem_addr, bus.mem_wdata);
      end
      if (wq.size() != 0) begin
        exp_w = wq.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(exp_w.addr));
        check("wr_data", 32'(bus.mem_wdata), 32'(exp_w.data));
      end
    end
  end

  always @(posedge clk) bus.mem_data_i <= mem[rd_addr_n];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle strobe; combinational side outputs are captured mid-cycle.
  task automatic strobe(input logic [2:0] r, input logic rw, input logic [7:0] d);
    bus.cpu_sel    = 1'b1;
    bus.cpu_reg    = r;
    bus.cpu_rw     = rw;
    bus.cpu_data_i = d;
    @(negedge clk);
    snap_pal_we    = bus.pal_we;
    snap_drop      = bus.drop;
    snap_pal_addr  = bus.pal_addr;
    snap_pal_wdata = bus.pal_wdata;
    @(posedge clk);
    #1;
    bus.cpu_sel = 1'b0;
  endtask

  task automatic set_v(input logic [13:0] a);
    strobe(3'd6, 1'b0, {2'b00, a[13:8]});
    strobe(3'd6, 1'b0, a[7:0]);
  endtask

  task automatic rd7(input string tag, input logic [7:0] exp);
    strobe(3'd7, 1'b1, 8'h00);
    check(tag, 32'(bus.cpu_data_o), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) pal[i] = 8'h00;
    rst            = 1'b0;
    bus.cpu_sel    = 1'b0;
    bus.cpu_reg    = 3'd0;
    bus.cpu_rw     = 1'b0;
    bus.cpu_data_i = 8'h00;
    bus.inc32      = 1'b0;
    bus.rend_req   = 1'b0;
    bus.rend_addr  = 14'h0000;
    tick(2);

    // Reset state
    check("rst_cpu_data", 32'(bus.cpu_data_o), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_rend_valid", 32'(bus.rend_valid), 32'h0);
    check("rst_pal_we", 32'(bus.pal_we), 32'h0);
    check("rst_drop", 32'(bus.drop), 32'h0);
    check("rst_v", 32'(bus.mem_addr), 32'h0000);
    rst = 1'b1;
    tick();

    // Address load and queued write, +1
    set_v(14'h2108);
    check("v_load", 32'(bus.mem_addr), 32'h2108);
    wq.push_back({14'h2108, 8'hAB});
    strobe(3'd7, 1'b0, 8'hAB);
    check("t1_busy", 32'(bus.busy), 32'h1);
    check("t1_mem_addr", 32'(bus.mem_addr), 32'h2108);
    check("t1_mem_rw", 32'(bus.mem_rw), 32'h0);
    check("t1_mem_wdata", 32'(bus.mem_wdata), 32'hAB);
    tick();
    check("t1_busy_clr", 32'(bus.busy), 32'h0);
    check("t1_v_inc", 32'(bus.mem_addr), 32'h2109);
    check("t1_idle_rw", 32'(bus.mem_rw), 32'h1);

    // Increment by 32
    bus.inc32 = 1'b1;
    set_v(14'h2000);
    wq.push_back({14'h2000, 8'h31});
    strobe(3'd7, 1'b0, 8'h31);
    tick(2);
    wq.push_back({14'h2020, 8'h32});
    strobe(3'd7, 1'b0, 8'h32);
    tick(2);
    check("t2_v", 32'(bus.mem_addr), 32'h2040);
    check("t2_wq_empty", 32'(wq.size()), 32'd0);
    bus.inc32 = 1'b0;

    // Buffered reads
    mem[14'h2000] = 8'h11;
    mem[14'h2001] = 8'h22;
    set_v(14'h2000);
    rd7("t3_rd0", 8'h00);
    tick(2);
    rd7("t3_rd1", 8'h11);
    tick(2);
    rd7("t3_rd2", 8'h22);
    tick(2);

    // Palette write then read with nametable refill
    set_v(14'h3F01);
    strobe(3'd7, 1'b0, 8'h0F);
    check("t4_pal_we", 32'(snap_pal_we), 32'h1);
    check("t4_pal_addr", 32'(snap_pal_addr), 32'h01);
    check("t4_pal_wdata", 32'(snap_pal_wdata), 32'h0F);
    check("t4_no_queue", 32'(bus.busy), 32'h0);
    check("t4_v_inc", 32'(bus.mem_addr), 32'h3F02);
    mem[14'h2F01] = 8'h5A;
    set_v(14'h3F01);
    rd7("t4_pal_rd", 8'h0F);
    check("t4_rd_no_pal_we", 32'(snap_pal_we), 32'h0);
    @(negedge clk);
    check("t4_refill_addr", 32'(bus.mem_addr), 32'h2F01);
    check("t4_refill_rw", 32'(bus.mem_rw), 32'h1);
    @(posedge clk);
    #1;
    set_v(14'h2000);
    rd7("t4_rd_buf", 8'h5A);
    tick(2);

    // Contention with render fetches
    set_v(14'h2300);
    bus.rend_addr = 14'h0123;
    bus.rend_req  = 1'b1;
    wq.push_back({14'h2300, 8'h77});
    strobe(3'd7, 1'b0, 8'h77);
    check("t5_drop0", 32'(snap_drop), 32'h0);
    check("t5_rend_valid", 32'(bus.rend_valid), 32'h1);
    check("t5_rend_addr", 32'(bus.mem_addr), 32'h0123);
    check("t5_rend_rw", 32'(bus.mem_rw), 32'h1);
    for (int i = 0; i < 2; i++) begin
      check("t5_busy_a", 32'(bus.busy), 32'h1);
      tick();
    end
    strobe(3'd7, 1'b0, 8'h88);
    check("t5_drop", 32'(snap_drop), 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("t5_busy_b", 32'(bus.busy), 32'h1);
      tick();
    end
    check("t5_busy_c", 32'(bus.busy), 32'h1);
    bus.rend_req = 1'b0;
    tick();
    check("t5_busy_clr", 32'(bus.busy), 32'h0);
    check("t5_wq_empty", 32'(wq.size()), 32'd0);
    check("t5_v_once", 32'(bus.mem_addr), 32'h2301);
    check("t5_rend_valid_clr", 32'(bus.rend_valid), 32'h0);

    // Reset mid-operation
    strobe(3'd6, 1'b0, 8'h25);
    bus.rend_req = 1'b1;
    strobe(3'd7, 1'b0, 8'h99);
    check("t6_busy_pre", 32'(bus.busy), 32'h1);
    check("t6_cpu_data_pre", 32'(bus.cpu_data_o), 32'h5A);
    #2;
    rst = 1'b0;
    #1;
    check("t6_cpu_data", 32'(bus.cpu_data_o), 32'h00);
    check("t6_busy", 32'(bus.busy), 32'h0);
    check("t6_rend_valid", 32'(bus.rend_valid), 32'h0);
    bus.rend_req = 1'b0;
    #1;
    check("t6_v", 32'(bus.mem_addr), 32'h0000);
    tick(2);
    rst = 1'b1;
    tick(3);
    set_v(14'h2108);
    check("t6_w_cleared", 32'(bus.mem_addr), 32'h2108);
    tick(2);
    check("final_wq_empty", 32'(wq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
